i2c_cfg_sequencer: RTL
======================

Name: i2c_cfg_sequencer

Overview:
Configures the external audio front-end over the shared I2C bus after power-up, before the speech datapath starts consuming samples. Walks a constant table of register writes and drives a byte-level I2C master engine through a valid/ready command port plus a response pulse. Retries NACKed writes with back-off and reports done/error status to top_ssr, which gates the sample-capture path on done.

Parameters:
N_REGS, 8, number of table entries (1..255)
DEV_ADDR, 7'h1A, 7-bit slave address
WAIT_CYCLES, 100000, power-up delay in clk cycles before the first write (0 = none)
MAX_RETRY, 3, attempts per entry before declaring failure (>=1)
BACKOFF_CYCLES, 1000, idle cycles between a NACK abort and the retry

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle request to run the sequence
busy  out  1  high from accepted start until DONE/FAIL
done  out  1  sticky; all entries ACKed
error  out  1  sticky; an entry exhausted MAX_RETRY
fail_idx  out  8  index of failing entry, valid while error=1
cmd_valid  out  1  command to byte engine
cmd_ready  in  1  engine accepts command
cmd_op  out  2  0 WR, 1 START_WR, 2 WR_STOP, 3 STOP_ONLY
cmd_data  out  8  byte to transmit (don't-care for STOP_ONLY)
rsp_valid  in  1  one-cycle pulse: byte/stop finished
rsp_ack  in  1  slave ACK on that byte (ignored for STOP_ONLY)

Behaviour:
- One clock; reset is asynchronous and active-high (clk, rst). Reset values: busy=0, done=0, error=0, fail_idx=0, cmd_valid=0, cmd_op=0, cmd_data=0; FSM=IDLE, all counters 0.
- States: IDLE, POWERUP, ISSUE, WAIT_RSP, ABORT, ABORT_WAIT, BACKOFF, DONE, FAIL.
- IDLE: start=1 -> clear done/error, entry=0, retry=0, byte=0, busy=1; go POWERUP (or straight to ISSUE if WAIT_CYCLES=0).
- POWERUP: count WAIT_CYCLES cycles exactly, then ISSUE. Power-up delay applies once per start, not per retry.
- Per entry, 3 bytes: byte0 = {DEV_ADDR,1'b0} op START_WR; byte1 = reg addr op WR; byte2 = reg data op WR_STOP.
- ISSUE: cmd_valid=1 with op/data registered; hold all stable until cmd_ready=1 (transfer on valid&&ready). Next cycle cmd_valid=0, WAIT_RSP. Exactly one outstanding command.
- WAIT_RSP on rsp_valid: ack=1 and byte<2 -> byte++, ISSUE. ack=1 and byte=2 -> entry++, byte=0, retry=0; entry was N_REGS-1 -> DONE else ISSUE. ack=0 -> ABORT. rsp_valid outside WAIT_RSP/ABORT_WAIT ignored.
- ABORT: issue STOP_ONLY (same handshake), then ABORT_WAIT for rsp_valid; then retry++; retry==MAX_RETRY -> FAIL, else BACKOFF. A NACK on byte2 is still aborted via STOP_ONLY.
- BACKOFF: BACKOFF_CYCLES idle cycles, then ISSUE with byte=0 of the same entry.
- DONE: done=1, busy=0, return IDLE; done stays 1 until next accepted start.
- FAIL: error=1, fail_idx=entry, busy=0, return IDLE; sticky until next start.
- start while busy: ignored. start same cycle as DONE/FAIL entry: ignored (accepted only in IDLE).
- No timeout on cmd_ready/rsp_valid; byte engine guarantees completion.
- Reset mid-operation: everything returns to reset values immediately; byte engine shares rst, so no STOP is issued.
- Counters: entry 8 bit, byte 2 bit, retry $clog2(MAX_RETRY+1), delay counter width $clog2(max(WAIT_CYCLES,BACKOFF_CYCLES)+1).

Decomposition:
- Package ssr_cfg_pkg: cmd_op enum (i2c_op_t), FSM state enum, cfg_entry_t struct {reg_addr[7:0], reg_data[7:0]}, constant array CFG_TABLE[N_REGS] for the front-end registers.
- Sub-module cfg_delay_counter (load/count/expired) shared by POWERUP and BACKOFF; all else in one FSM module.

Test Plan:
- N_REGS=2, WAIT_CYCLES=10, engine always ACK, ready immediate -> 6 commands in order START_WR 0x34, WR, WR_STOP x2; first cmd_valid exactly 11 cycles after start; done=1, busy=0, error=0.
- Engine holds cmd_ready low 5 cycles per command -> cmd_valid/op/data stable throughout, no duplicate transfer, same byte sequence.
- Entry 1 byte1 NACKed once, BACKOFF_CYCLES=4 -> STOP_ONLY issued, 4 idle cycles, entry 1 restarts at START_WR; done=1.
- Entry 0 byte0 NACKed always, MAX_RETRY=3 -> 3 attempts each followed by STOP_ONLY, then error=1, fail_idx=0, done=0.
- start pulsed while busy, then rst asserted mid-WAIT_RSP -> second start ignored; on rst all outputs 0 in the same cycle; new start reruns from entry 0 incl. power-up delay.

Source files
------------

// File: rtl/ssr_cfg_pkg.sv
// Shared types and the audio front-end register table for the I2C
// configuration sequencer.
//   i2c_op_t     : command opcode presented to the byte engine
//   cfg_state_t  : sequencer FSM states
//   cfg_entry_t  : one register write (address, data)
//   CFG_TABLE    : power-up register image, walked from index 0
package ssr_cfg_pkg;

    typedef enum logic [1:0] {
        OP_WR        = 2'd0,
        OP_START_WR  = 2'd1,
        OP_WR_STOP   = 2'd2,
        OP_STOP_ONLY = 2'd3
    } i2c_op_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_POWERUP,
        ST_ISSUE,
        ST_WAIT_RSP,
        ST_ABORT,
        ST_ABORT_WAIT,
        ST_BACKOFF,
        ST_DONE,
        ST_FAIL
    } cfg_state_t;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] reg_data;
    } cfg_entry_t;

    localparam int CFG_N_REGS = 8;

    localparam cfg_entry_t CFG_TABLE [CFG_N_REGS] = '{
        '{8'h0C, 8'h10},
        '{8'h0E, 8'h42},
        '{8'h10, 8'h00},
        '{8'h00, 8'h17},
        '{8'h02, 8'h17},
        '{8'h08, 8'h12},
        '{8'h0A, 8'h06},
        '{8'h12, 8'h01}
    };

    // Indices past the end of the table read as a write of 0x00 to register 0x00.
    function automatic cfg_entry_t cfg_lookup(input logic [7:0] idx);
        cfg_entry_t e;
        e = '0;
        for (int i = 0; i < CFG_N_REGS; i++) begin
            if (idx == 8'(i)) e = CFG_TABLE[i];
        end
        return e;
    endfunction

endpackage

// File: rtl/i2c_cfg_sequencer_if.sv
// Command/response link between the configuration sequencer (master) and
// the byte-level I2C engine (slave).
//   cmd_valid/cmd_ready : command handshake, transfer on valid && ready
//   cmd_op/cmd_data     : opcode and byte to transmit
//   rsp_valid/rsp_ack   : one-cycle completion pulse and slave ACK
interface i2c_cfg_sequencer_if;
    import ssr_cfg_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    i2c_op_t    cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ack;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, rsp_valid, rsp_ack
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, rsp_valid, rsp_ack
    );

endinterface

// File: rtl/cfg_delay_counter.sv
// Down-counter used for both the power-up wait and the retry back-off.
//   clk, rst  : clock, async active-high reset
//   load      : load load_val (takes priority over count)
//   load_val  : value to load; expired rises load_val+1 counting cycles later
//   count     : decrement while non-zero
//   expired   : counter is at zero
module cfg_delay_counter #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             count,
    output logic             expired
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (count && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks CFG_TABLE after power-up, writing each entry to the front-end over
// I2C as START_WR(dev addr) / WR(reg addr) / WR_STOP(reg data). NACKed
// entries are aborted with STOP_ONLY, backed off and retried.
//   clk, rst          : clock, async active-high reset
//   start             : one-cycle run request, honoured only in IDLE
//   busy              : sequence in progress
//   done / error      : sticky completion / failure status
//   fail_idx          : entry that exhausted its retries
//   bus (master)      : command/response link to the byte engine
//
// state       | meaning
// IDLE        | waiting for start
// POWERUP     | front-end power-up delay, once per start
// ISSUE       | data command presented, waiting for cmd_ready
// WAIT_RSP    | waiting for the byte result
// ABORT       | STOP_ONLY presented after a NACK
// ABORT_WAIT  | waiting for the STOP to finish
// BACKOFF     | idle gap before retrying the entry from byte 0
// DONE        | all entries ACKed
// FAIL        | entry out of retries
module i2c_cfg_sequencer
    import ssr_cfg_pkg::*;
#(
    parameter int         N_REGS         = CFG_N_REGS,
    parameter logic [6:0] DEV_ADDR       = 7'h1A,
    parameter int         WAIT_CYCLES    = 100000,
    parameter int         MAX_RETRY      = 3,
    parameter int         BACKOFF_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [7:0]          fail_idx,
    i2c_cfg_sequencer_if.master bus
);

    localparam int RW      = $clog2(MAX_RETRY + 1);
    localparam int DLY_MAX = (WAIT_CYCLES > BACKOFF_CYCLES) ? WAIT_CYCLES : BACKOFF_CYCLES;
    localparam int DW      = (DLY_MAX < 2) ? 1 : $clog2(DLY_MAX + 1);

    cfg_state_t    state_q, state_d;
    logic [7:0]    entry_q, entry_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [7:0]    fail_idx_q, fail_idx_d;
    logic          cmd_valid_q, cmd_valid_d;
    i2c_op_t       cmd_op_q, cmd_op_d;
    logic [7:0]    cmd_data_q, cmd_data_d;

    logic          dly_load, dly_count, dly_expired;
    logic [DW-1:0] dly_val;
    logic          issue_next;

    function automatic i2c_op_t byte_op(input logic [1:0] b);
        case (b)
            2'd0:    return OP_START_WR;
            2'd1:    return OP_WR;
            default: return OP_WR_STOP;
        endcase
    endfunction

    function automatic logic [7:0] byte_data(input logic [7:0] idx, input logic [1:0] b);
        cfg_entry_t e;
        e = cfg_lookup(idx);
        case (b)
            2'd0:    return {DEV_ADDR, 1'b0};
            2'd1:    return e.reg_addr;
            default: return e.reg_data;
        endcase
    endfunction

    cfg_delay_counter #(.WIDTH(DW)) u_delay (
        .clk      (clk),
        .rst      (rst),
        .load     (dly_load),
        .load_val (dly_val),
        .count    (dly_count),
        .expired  (dly_expired)
    );

    always_comb begin
        state_d     = state_q;
        entry_d     = entry_q;
        byte_idx_d  = byte_idx_q;
        retry_d     = retry_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        fail_idx_d  = fail_idx_q;
        cmd_valid_d = cmd_valid_q;
        cmd_op_d    = cmd_op_q;
        cmd_data_d  = cmd_data_q;
        dly_load    = 1'b0;
        dly_val     = '0;
        dly_count   = 1'b0;
        // Set wherever the next state is ISSUE; the command for
        // entry_d/byte_idx_d is registered below so it is stable from the
        // first cycle cmd_valid is high.
        issue_next  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    fail_idx_d = '0;
                    entry_d    = '0;
                    byte_idx_d = '0;
                    retry_d    = '0;
                    busy_d     = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        issue_next = 1'b1;
                    end else begin
                        state_d  = ST_POWERUP;
                        dly_load = 1'b1;
                        dly_val  = DW'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_POWERUP, ST_BACKOFF: begin
                dly_count = 1'b1;
                if (dly_expired) issue_next = 1'b1;
            end
            ST_ISSUE: begin
                if (bus.cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (bus.rsp_valid) begin
                    if (!bus.rsp_ack) begin
                        state_d     = ST_ABORT;
                        cmd_valid_d = 1'b1;
                        cmd_op_d    = OP_STOP_ONLY;
                        cmd_data_d  = '0;
                    end else if (byte_idx_q != 2'd2) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        issue_next = 1'b1;
                    end else begin
                        byte_idx_d = '0;
                        retry_d    = '0;
                        entry_d    = entry_q + 8'd1;
                        if (entry_q == 8'(N_REGS - 1)) state_d = ST_DONE;
                        else                           issue_next = 1'b1;
                    end
                end
            end
            ST_ABORT: begin
                if (bus.cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = ST_ABORT_WAIT;
                end
            end
            ST_ABORT_WAIT: begin
                if (bus.rsp_valid) begin
                    retry_d    = retry_q + 1'b1;
                    byte_idx_d = '0;
                    if (retry_d == RW'(MAX_RETRY)) begin
                        state_d = ST_FAIL;
                    end else if (BACKOFF_CYCLES == 0) begin
                        issue_next = 1'b1;
                    end else begin
                        state_d  = ST_BACKOFF;
                        dly_load = 1'b1;
                        dly_val  = DW'(BACKOFF_CYCLES - 1);
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            ST_FAIL: begin
                error_d    = 1'b1;
                fail_idx_d = entry_q;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue_next) begin
            state_d     = ST_ISSUE;
            cmd_valid_d = 1'b1;
            cmd_op_d    = byte_op(byte_idx_d);
            cmd_data_d  = byte_data(entry_d, byte_idx_d);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            entry_q     <= '0;
            byte_idx_q  <= '0;
            retry_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            fail_idx_q  <= '0;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= OP_WR;
            cmd_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            byte_idx_q  <= byte_idx_d;
            retry_q     <= retry_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            fail_idx_q  <= fail_idx_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_op_q    <= cmd_op_d;
            cmd_data_q  <= cmd_data_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign fail_idx      = fail_idx_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_op    = cmd_op_q;
    assign bus.cmd_data  = cmd_data_q;

endmodule
